// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU Wishbone master: access sizes, FSM states,
// default bus timeout and the alignment rule for a request.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_GAP    = 3'd3,
    S_WR     = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  // Illegal size is folded in so the caller only needs a range check on top.
  function automatic logic bad_align(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: bad_align = lo[0];
      SZ_WORD: bad_align = (lo != 2'b00);
      SZ_ILL:  bad_align = 1'b1;
      default: bad_align = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a bus word,
// and merges byte/half store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = rd_word_i[{lane_i, 3'b000} +: 8];
    half_sel    = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    load_data_o = rd_word_i;
    merged_o    = rd_word_i;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        load_data_o = rd_word_i;
        merged_o    = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// Load/store unit front end: turns single CPU requests into Wishbone classic
// cycles, using read-modify-write for byte and half stores.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | req_ready high, waiting for a request
// RD       | load bus read in progress
// RMW_RD   | read phase of a sub-word store
// GAP      | one idle cycle so the slave's trailing ack is not reused
// WR       | bus write (word store, or merged word of a sub-word store)
// DONE     | one-cycle response pulse
module lsu_wb_master
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]      lane_q;
  size_e           size_q;
  logic            uns_q;
  logic            we_q;
  logic [31:0]     wdata_q;

  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic [ADDR_WIDTH-1:0] wb_adr_q;
  logic [31:0]     wb_dat_q;
  logic            wb_we_q;
  logic            wb_cyc_q;

  logic            req_err_d;
  logic [31:0]     load_data_d;
  logic [31:0]     merged_d;

  assign req_err_d = bad_align(size_e'(req_size), req_addr[1:0]) ||
                     ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  lsu_lane_align u_lane_align (
    .lane_i      (lane_q),
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .rd_word_i   (wb_dat_i),
    .wdata_i     (wdata_q),
    .load_data_o (load_data_d),
    .merged_o    (merged_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lane_q      <= 2'b00;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_cyc_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            lane_q      <= req_addr[1:0];
            size_q      <= size_e'(req_size);
            uns_q       <= req_unsigned;
            we_q        <= req_we;
            wdata_q     <= req_wdata;
            cnt_q       <= '0;
            if (req_err_d) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              wb_adr_q <= req_addr[ADDR_WIDTH+1:2];
              wb_cyc_q <= 1'b1;
              if (!req_we) begin
                state_q <= S_RD;
              end else if (size_e'(req_size) == SZ_WORD) begin
                state_q  <= S_WR;
                wb_we_q  <= 1'b1;
                wb_dat_q <= req_wdata;
              end else begin
                state_q <= S_RMW_RD;
              end
            end
          end
        end
        S_RD, S_RMW_RD: begin
          if (wb_ack_i) begin
            wb_cyc_q <= 1'b0;
            cnt_q    <= '0;
            if (state_q == S_RD) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= we_q ? 32'd0 : load_data_d;
            end else begin
              state_q  <= S_GAP;
              wb_dat_q <= merged_d;
            end
          end else if (cnt_q == CNT_LAST) begin
            wb_cyc_q    <= 1'b0;
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          state_q  <= S_WR;
          wb_cyc_q <= 1'b1;
          wb_we_q  <= 1'b1;
          cnt_q    <= '0;
        end
        S_WR: begin
          if (wb_ack_i || cnt_q == CNT_LAST) begin
            wb_cyc_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~wb_ack_i;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          req_ready_q <= 1'b1;
          cnt_q       <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wb_adr_o  = wb_adr_q;
  assign wb_dat_o  = wb_dat_q;
  assign wb_we_o   = wb_we_q;
  assign wb_stb_o  = wb_cyc_q;
  assign wb_cyc_o  = wb_cyc_q;

endmodule
